// File: rtl/seq_mult_ctrl.sv
// Sequential 8x8 -> 16 unsigned shift-and-add multiplier controller.
// It uses an external shared 4-bit adder, one nibble per cycle.
// Optional build macro: SKIP_ZERO_EN. When defined, a zero multiplier bit costs one SHIFT cycle
// instead of an ADD_LO/ADD_HI pair.
// product_o is loaded on the edge that enters DONE, so it is already valid while done_o is high.
module seq_mult_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  multiplicand_i,
  input  logic [7:0]  multiplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] product_o,
  output logic [3:0]  add_a_o,
  output logic [3:0]  add_b_o,
  output logic        add_cin_o,
  input  logic [3:0]  add_sum_i,
  input  logic        add_cout_i
);

`ifdef SKIP_ZERO_EN
  typedef enum logic [2:0] {StIdle, StAddLo, StAddHi, StShift, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StAddLo, StAddHi, StDone} state_e;
`endif

  state_e      state_q;
  logic [8:0]  acc_q;      // accumulator A, bit 8 is the carry position
  logic [7:0]  q_q;        // multiplier shift register Q
  logic [7:0]  m_q;        // captured multiplicand M
  logic        c_q;        // carry from the low-nibble add into the high-nibble add
  logic [2:0]  cnt_q;      // index of the multiplier bit being processed
  logic [15:0] product_q;

  // {A, Q} after the ADD_HI right shift. A[8] is always clear entering ADD_HI, so OR-ing it into
  // the carry keeps the full 9-bit accumulator in the datapath without changing the result.
  logic [16:0] addhi_shift;
  assign addhi_shift = {1'b0, add_cout_i | acc_q[8], add_sum_i, acc_q[3:0], q_q[7:1]};

`ifdef SKIP_ZERO_EN
  // {A, Q} after a plain right shift, used when the current multiplier bit is zero
  logic [16:0] zero_shift;
  assign zero_shift = {1'b0, acc_q, q_q[7:1]};
`endif

  // Adder operand drive; ports are held at zero outside the two add states
  always_comb begin
    add_a_o   = 4'h0;
    add_b_o   = 4'h0;
    add_cin_o = 1'b0;
    case (state_q)
      StAddLo: begin
        add_a_o = acc_q[3:0];
        add_b_o = q_q[0] ? m_q[3:0] : 4'h0;
      end
      StAddHi: begin
        add_a_o   = acc_q[7:4];
        add_b_o   = q_q[0] ? m_q[7:4] : 4'h0;
        add_cin_o = c_q;
      end
      default: ;
    endcase
  end

  // Status outputs decode directly from the state register
  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign product_o = product_q;

  // Controller FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      acc_q     <= 9'h000;
      q_q       <= 8'h00;
      m_q       <= 8'h00;
      c_q       <= 1'b0;
      cnt_q     <= 3'd0;
      product_q <= 16'h0000;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            m_q   <= multiplicand_i;
            q_q   <= multiplier_i;
            acc_q <= 9'h000;
            c_q   <= 1'b0;
            cnt_q <= 3'd0;
`ifdef SKIP_ZERO_EN
            state_q <= multiplier_i[0] ? StAddLo : StShift;
`else
            state_q <= StAddLo;
`endif
          end
        end
        StAddLo: begin
          acc_q[3:0] <= add_sum_i;
          c_q        <= add_cout_i;
          state_q    <= StAddHi;
        end
        StAddHi: begin
          acc_q <= addhi_shift[16:8];
          q_q   <= addhi_shift[7:0];
          if (cnt_q == 3'd7) begin
            product_q <= addhi_shift[15:0];
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 3'd1;
`ifdef SKIP_ZERO_EN
            state_q <= addhi_shift[0] ? StAddLo : StShift;
`else
            state_q <= StAddLo;
`endif
          end
        end
`ifdef SKIP_ZERO_EN
        StShift: begin
          acc_q <= zero_shift[16:8];
          q_q   <= zero_shift[7:0];
          if (cnt_q == 3'd7) begin
            product_q <= zero_shift[15:0];
            state_q   <= StDone;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            state_q <= zero_shift[0] ? StAddLo : StShift;
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl; also valid when built with SKIP_ZERO_EN defined.
module tb_seq_mult_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  mcand = 8'h00;
  logic [7:0]  mplier = 8'h00;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;

  int n_checks = 0;
  int n_errors = 0;

  // Adder port values seen in the first ADD_LO and first ADD_HI cycles of the last operation
  logic [8:0] snap_lo;
  logic [8:0] snap_hi;

  always #5 clk_i = ~clk_i;

  // Reference 4-bit adder shared with the DUT
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  seq_mult_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .multiplicand_i (mcand),
    .multiplier_i   (mplier),
    .busy_o         (busy),
    .done_o         (done),
    .product_o      (product),
    .add_a_o        (add_a),
    .add_b_o        (add_b),
    .add_cin_o      (add_cin),
    .add_sum_i      (add_sum),
    .add_cout_i     (add_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge (counted from the accepting edge 0) after which done_o is high
  function automatic int exp_lat(input logic [7:0] q);
`ifdef SKIP_ZERO_EN
    return 8 + $countones(q);
`else
    return 16;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // glitch > 0 raises start_i (with operands 1x1) for the edge of that number mid-operation.
  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input int glitch, output logic [15:0] prod);
    int lat;
    int busy_cnt;
    lat      = -1;
    busy_cnt = 0;
    prod     = 16'hxxxx;
    start_i  = 1'b1;
    mcand    = m;
    mplier   = q;
    @(negedge clk_i);
    // Operand changes after acceptance must not disturb the operation
    start_i = 1'b0;
    mcand   = 8'h5A;
    mplier  = 8'hC3;
    for (int e = 0; e <= 40; e++) begin
      if (busy) busy_cnt++;
      if (e == 0) snap_lo = {add_a, add_b, add_cin};
      if (e == 1) snap_hi = {add_a, add_b, add_cin};
      if (glitch > 0 && e == glitch - 1) begin
        start_i = 1'b1;
        mcand   = 8'h01;
        mplier  = 8'h01;
      end
      if (glitch > 0 && e == glitch) start_i = 1'b0;
      if (done) begin
        lat  = e;
        prod = product;
        chk({tag, "_done_adder_idle"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
        break;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat(q));
    if (lat >= 0) begin
      chk({tag, "_busy_cycles"}, busy_cnt, lat + 1);
      @(negedge clk_i);
      chk({tag, "_done_pulse_low"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      chk({tag, "_product_held"}, {16'd0, product}, {16'd0, prod});
    end
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  rm;
    logic [7:0]  rq;

    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Largest operands; first start accepted on first edge after reset release
    run_op("ff_ff", 8'hFF, 8'hFF, -1, p);
    chk("ff_ff_product", {16'd0, p}, 32'hFE01);

    // Back-to-back start with an ignored start pulse at edge 5
    run_op("0f_11", 8'h0F, 8'h11, 5, p);
    chk("0f_11_product", {16'd0, p}, 32'h00FF);

    run_op("00_a5", 8'h00, 8'hA5, -1, p);
    chk("00_a5_product", {16'd0, p}, 32'h0000);

    // Adder port contents: ADD_LO 0+8, then ADD_HI 0+F with no carry-in
    run_op("f8_01", 8'hF8, 8'h01, -1, p);
    chk("f8_01_product", {16'd0, p}, 32'h00F8);
    chk("f8_01_addlo_ports", {23'd0, snap_lo}, {23'd0, 4'h0, 4'h8, 1'b0});
    chk("f8_01_addhi_ports", {23'd0, snap_hi}, {23'd0, 4'h0, 4'hF, 1'b0});

    // Reset mid-operation at edge 7
    start_i = 1'b1;
    mcand   = 8'h12;
    mplier  = 8'h34;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_product", {16'd0, product}, 32'd0);
    chk("mid_rst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op("03_05", 8'h03, 8'h05, -1, p);
    chk("03_05_product", {16'd0, p}, 32'h000F);

    // Sparse multipliers (shorter latency when zero bits are skipped)
    run_op("ab_01", 8'hAB, 8'h01, -1, p);
    chk("ab_01_product", {16'd0, p}, 32'h00AB);
    run_op("ab_00", 8'hAB, 8'h00, -1, p);
    chk("ab_00_product", {16'd0, p}, 32'h0000);

    // Random back-to-back regression
    for (int i = 0; i < 150; i++) begin
      rm = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      run_op("rand", rm, rq, -1, p);
      chk("rand_product", {16'd0, p}, {16'd0, 16'(rm) * 16'(rq)});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
